// File: rtl/aes_stream_loader_if.sv
// aes_stream_loader_if: word/key/ciphertext handshake bundle for aes_stream_loader.
// blk_count exists only when AES_BLOCK_COUNT_EN is defined.
interface aes_stream_loader_if;
  logic [31:0] in_word;
  logic in_valid, in_ready;
  logic [127:0] key_in;
  logic key_load, key_ready;
  logic [127:0] pt_out, key_out, ct_in, ct_data;
  logic ct_valid, ct_ready, busy;
`ifdef AES_BLOCK_COUNT_EN
  logic [31:0] blk_count;
`endif
  modport master (
    output in_word, in_valid, key_in, key_load, ct_in, ct_ready,
`ifdef AES_BLOCK_COUNT_EN
    input blk_count,
`endif
    input in_ready, key_ready, pt_out, key_out, ct_data, ct_valid, busy
  );
  modport slave (
    input in_word, in_valid, key_in, key_load, ct_in, ct_ready,
`ifdef AES_BLOCK_COUNT_EN
    output blk_count,
`endif
    output in_ready, key_ready, pt_out, key_out, ct_data, ct_valid, busy
  );
endinterface

// File: rtl/aes_stream_loader.sv
// aes_stream_loader: packs words into blocks, credit-gates issue to a fixed-latency AES-128 core and buffers its ciphertext.
// AES_BLOCK_COUNT_EN adds the blk_count popped-block counter.
module aes_stream_loader #(
  parameter int PIPE_LAT = 11,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  aes_stream_loader_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);
  logic [1:0] word_cnt;
  logic block_full, issue_q, word_accept, key_accept, can_issue, push, pop, not_empty;
  logic [127:0] staging, pt_q, key_q;
  logic [PIPE_LAT-1:0] tag_sr;
  logic [CW-1:0] in_flight, fifo_count;
  logic [CW:0] outstanding;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [127:0] mem [FIFO_DEPTH];
  assign bus.in_ready = rst_n && !block_full;
  assign bus.key_ready = rst_n && in_flight == '0 && !issue_q;
  assign word_accept = bus.in_valid && bus.in_ready;
  assign key_accept = bus.key_load && bus.key_ready;
  // every issued block owns a FIFO slot, so the core can never outrun the consumer
  assign outstanding = {1'b0, in_flight} + {1'b0, fifo_count};
  assign can_issue = block_full && outstanding < DEPTH && !key_accept;
  assign push = tag_sr[PIPE_LAT-1];
  assign not_empty = fifo_count != '0;
  assign pop = not_empty && bus.ct_ready;
  assign bus.ct_valid = not_empty;
  assign bus.ct_data = not_empty ? mem[rd_ptr] : '0;
  assign bus.pt_out = pt_q;
  assign bus.key_out = key_q;
  assign bus.busy = word_cnt != '0 || block_full || in_flight != '0 || not_empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word_cnt <= '0;
      block_full <= 1'b0;
      staging <= '0;
      pt_q <= '0;
      key_q <= '0;
      issue_q <= 1'b0;
      tag_sr <= '0;
      in_flight <= '0;
      fifo_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (word_accept) begin
        staging[127 - 32*word_cnt -: 32] <= bus.in_word;
        word_cnt <= word_cnt + 2'd1;
      end
      if (can_issue) block_full <= 1'b0;
      else if (word_accept && word_cnt == 2'd3) block_full <= 1'b1;
      if (can_issue) pt_q <= staging;
      if (key_accept) key_q <= bus.key_in;
      issue_q <= can_issue;
      tag_sr <= PIPE_LAT'({tag_sr, issue_q});
      in_flight <= in_flight + CW'(can_issue) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.ct_in;
`ifdef AES_BLOCK_COUNT_EN
  logic [31:0] blk_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blk_cnt <= '0;
    else if (pop) blk_cnt <= blk_cnt + 32'd1;
  assign bus.blk_count = blk_cnt;
`endif
endmodule

// File: tb/tb_aes_stream_loader.sv
// tb_aes_stream_loader: random and directed traffic against a queue-based model with a reference AES-128 core
// behind a PIPE_LAT delay line; checks blk_count when AES_BLOCK_COUNT_EN is defined.
module tb_aes_stream_loader;
  localparam int PIPE_LAT = 11;
  localparam int FIFO_DEPTH = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rnd_rdy = 1'b0;
  int n_chk = 0, n_fail = 0, pops_rst = 0;
  logic [127:0] exp_q [$];
  logic [127:0] mkey = '0, part = '0;
  int pw = 0;
  logic [127:0] cq [PIPE_LAT];
  logic [7:0] sbox [256];
  aes_stream_loader_if bus();
  aes_stream_loader #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction
  initial
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0] st [16];
    logic [7:0] tmp [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] t;
    logic [127:0] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox[s[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) tmp[q + 4*c] = st[q + 4*((c + q) % 4)];
      st = tmp;
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = st[i];
      s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // reference core: samples pt_out/key_out each edge, answers PIPE_LAT cycles later
  always begin
    @(posedge clk);
    for (int i = PIPE_LAT - 1; i > 0; i--) cq[i] <= cq[i-1];
    cq[0] <= aes_enc(bus.pt_out, bus.key_out);
  end
  assign bus.ct_in = cq[PIPE_LAT-1];

  // model: a completed block is owed aes(block, key in force when it completed), in arrival order
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      pw = 0;
      mkey = '0;
      pops_rst = 0;
    end else begin
      if (bus.key_load && bus.key_ready) mkey = bus.key_in;
      if (bus.in_valid && bus.in_ready) begin
        part[127 - 32*pw -: 32] = bus.in_word;
        pw++;
        if (pw == 4) begin
          exp_q.push_back(aes_enc(part, mkey));
          pw = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    if (rst_n) begin
      chk("fifo_overflow", dut.push && !dut.pop && int'(dut.fifo_count) == FIFO_DEPTH, 1'b0);
      if (bus.ct_valid && bus.ct_ready) begin
        if (exp_q.size() == 0) chk("ct_unexpected", bus.ct_data, 128'hx);
        else chk("ct_data", bus.ct_data, exp_q.pop_front());
        pops_rst++;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.ct_ready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_word(input logic [31:0] w);
    int t;
    t = 0;
    bus.in_word = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 300) begin step(); t++; end
    if (t >= 300) chk("in_ready_timeout", 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic send_block(input logic [127:0] b);
    for (int i = 0; i < 4; i++) send_word(b[127 - 32*i -: 32]);
  endtask
  task automatic load_key(input logic [127:0] k);
    int t;
    t = 0;
    bus.key_in = k;
    bus.key_load = 1'b1;
    while (!bus.key_ready && t < 300) begin step(); t++; end
    if (t >= 300) chk("key_ready_timeout", 1'b0, 1'b1);
    step();
    bus.key_load = 1'b0;
  endtask
  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 600) begin step(); t++; end
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", bus.busy, 1'b0);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pt_out"}, bus.pt_out, '0);
    chk({tag, "_key_out"}, bus.key_out, '0);
    chk({tag, "_ct_data"}, bus.ct_data, '0);
    chk({tag, "_ct_valid"}, bus.ct_valid, 1'b0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_key_ready"}, bus.key_ready, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, cnt;
    logic [127:0] blk [6];
    logic [127:0] k2;
    bus.in_word = '0;
    bus.in_valid = 1'b0;
    bus.key_in = '0;
    bus.key_load = 1'b0;
    bus.ct_ready = 1'b1;
    repeat (2) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // FIPS-197 vector and end-to-end latency
    load_key(FIPS_KEY);
    send_block(FIPS_PT);
    cnt = 0;
    while (!bus.ct_valid && cnt < 100) begin step(); cnt++; end
    chk("fips_latency", 32'(cnt), 32'(PIPE_LAT + 2));
    chk("fips_ct", bus.ct_data, FIPS_CT);
    step();
    chk("fips_valid_one_cycle", bus.ct_valid, 1'b0);
    wait_drain();

    // backpressure: 4 blocks in flight/FIFO, 5th staged, 6th held off
    bus.ct_ready = 1'b0;
    for (int b = 0; b < 6; b++) blk[b] = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < 5; b++) send_block(blk[b]);
    bus.in_word = blk[5][127:96];
    bus.in_valid = 1'b1;
    repeat (30) step();
    chk("bp_in_ready", bus.in_ready, 1'b0);
    chk("bp_last_issued", bus.pt_out, blk[3]);
    chk("bp_ct_valid", bus.ct_valid, 1'b1);
    chk("bp_model_pending", 32'(exp_q.size()), 32'd5);
    cnt = pops_rst;
    bus.ct_ready = 1'b1;
    send_block(blk[5]);
    wait_drain();
    chk("bp_pop_count", 32'(pops_rst - cnt), 32'd6);

    // key change under traffic
    send_block({$urandom, $urandom, $urandom, $urandom});
    repeat (3) step();
    k2 = {$urandom, $urandom, $urandom, $urandom};
    bus.key_in = k2;
    bus.key_load = 1'b1;
    chk("kc_key_blocked", bus.key_ready, 1'b0);
    t = 0;
    while (!bus.key_ready && t < 100) begin step(); t++; end
    chk("kc_key_wait", 32'(t), 32'(PIPE_LAT - 1));
    step();
    bus.key_load = 1'b0;
    chk("kc_key_out", bus.key_out, k2);
    send_block({$urandom, $urandom, $urandom, $urandom});
    wait_drain();

    // reset with two blocks in flight and one staged word
    for (int b = 0; b < 2; b++) send_block({$urandom, $urandom, $urandom, $urandom});
    send_word($urandom);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.ct_valid) cnt++; end
    chk("midrst_no_ct", 32'(cnt), 32'd0);
    load_key(FIPS_KEY);
    send_block(FIPS_PT);
    t = 0;
    while (!bus.ct_valid && t < 100) begin step(); t++; end
    chk("midrst_fips_ct", bus.ct_data, FIPS_CT);
    wait_drain();

    // random traffic with random consumer stalls and key changes between bursts
    for (int r = 0; r < 3; r++) begin
      load_key({$urandom, $urandom, $urandom, $urandom});
      rnd_rdy = 1'b1;
      for (int b = 0; b < 10; b++)
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send_word($urandom);
        end
      rnd_rdy = 1'b0;
      bus.ct_ready = 1'b1;
      wait_drain();
    end

`ifdef AES_BLOCK_COUNT_EN
    chk("blk_count", bus.blk_count, 128'(pops_rst));
    force dut.blk_cnt = 32'hFFFFFFFF;
    step();
    release dut.blk_cnt;
    chk("blk_count_forced", bus.blk_count, 128'h0FFFFFFFF);
    send_block(FIPS_PT);
    wait_drain();
    chk("blk_count_wrap", bus.blk_count, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
